conv_layer_stream: RTL and testbench
====================================

Name: conv_layer_stream

Overview:
Parametrised 3x3 convolution layer engine. It streams one image channel row-by-row through a 3-row line buffer, reusing 2 rows per step. It convolves each window with N_KER kernels in parallel and emits one output pixel per kernel per handshake, in raster order. It sits between the image row fetcher and the per-kernel output memories. It also adds weight-load sequencing, weight reuse across images, output fixed-point scaling with saturation, and valid/ready back-pressure.

Parameters:
WIDTH, 9, signed data/weight word width
IMG_W, 32, input image columns (>=3)
IMG_H, 32, input image rows (>=3)
N_KER, 3, kernels applied in parallel
SHIFT, 0, arithmetic right shift applied to each accumulated sum before saturation

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one image; sampled only in IDLE
reuse_w  in  1  sampled with start; 1 = skip weight load, keep stored kernels
w_valid  in  1  weight word valid
w_data  in  WIDTH  weight word; order: kernel 0..N_KER-1, each row-major k00..k22
w_ready  out  1  weight word accepted when w_valid&w_ready
row_valid  in  1  image row valid
row_data  in  IMG_W*WIDTH  one image row; column c at bits [c*WIDTH +: WIDTH]
row_ready  out  1  row accepted when row_valid&row_ready
out_valid  out  1  output pixel set valid
out_ready  in  1  downstream accepts output
out_data  out  N_KER*WIDTH  kernel k result at bits [k*WIDTH +: WIDTH]
out_row  out  $clog2(IMG_H-2)  output row index
out_col  out  $clog2(IMG_W-2)  output column index
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last output accepted

Behaviour:
- Reset: state IDLE. w_ready, row_ready, out_valid, out_data, out_row, out_col, busy, done are all 0. Line buffer and row counter are cleared. Stored weights are cleared to 0. Reset mid-operation aborts immediately; no partial done.
- States: IDLE, LOAD_W, FILL, CONV, DONE.
- IDLE: on start, go to FILL if reuse_w=1, else go to LOAD_W. start in any other state is ignored.
- LOAD_W: w_ready=1. Each accepted word is written to index 0..9*N_KER-1. After word 9*N_KER-1 is accepted, go to FILL.
- FILL: row_ready=1. Accepted rows shift into the line buffer (oldest discarded). After 3 rows total have been accepted for this image, go to CONV with col=0.
- CONV: row_ready=0. The window covers buffer rows 0..2 and columns col..col+2.
  - Results are registered: out_valid rises 1 cycle after entering CONV or after the previous handshake.
  - While out_valid=1 and out_ready=0, out_data, out_row and out_col hold stable.
  - On each handshake, col increments.
  - After the handshake at col=IMG_W-3:
    - if out_row<IMG_H-3: out_row increments and the state returns to FILL, which needs exactly 1 new row before re-entering CONV;
    - otherwise go to DONE.
  - out_valid drops in the cycle after the final handshake of a row.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic:
  - Each product is a signed WIDTH x WIDTH multiply giving 2*WIDTH bits.
  - 9 products are summed in a 2*WIDTH+4 bit signed accumulator, so there is no overflow.
  - The sum is arithmetically shifted right by SHIFT, then saturated to the signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Throughput: 1 output set per cycle when out_ready is held high. Each row incurs 1 extra FILL cycle plus 1 result-register cycle.
- Output count per image: (IMG_H-2)*(IMG_W-2) output sets.
- Weights persist across images until reset or the next LOAD_W.

Test Plan:
1. IMG_W=5, IMG_H=5, N_KER=2, SHIFT=0.
   - Stimulus: kernel0 all 1, kernel1 centre 1 and others 0, pixel(r,c)=r*5+c.
   - Required: 9 outputs in raster order. (0,0) gives k0=54, k1=6. (2,2) gives k0=162, k1=18, which saturates to 255 with WIDTH=9? No: 162 fits, 18 fits. done pulses once after out (2,2) is accepted.
2. Saturation, WIDTH=9, all weights 255, all pixels 255 (sum 585225).
   - SHIFT=0: every output is 255.
   - Weights -256 with pixels 255: every output is -256.
3. Back-pressure with the test 1 image: toggle out_ready 0/1 every cycle.
   - Required: identical 9 values in identical order; out_data/out_row/out_col stable whenever out_valid=1 and out_ready=0.
4. Weight reuse: run test 1, then start with reuse_w=1 and hold w_valid high.
   - Required: w_ready stays 0, the row fetch begins immediately, and outputs equal test 1.
5. Assert rst_n=0 for 1 cycle during CONV at out_row=1.
   - Required: all outputs are 0 immediately and done never pulses.
   - A new start with reuse_w=1 convolves with zero weights, so all outputs are 0.
6. Pulse start while busy=1.
   - Required: no effect on the state or the output sequence.

Source files
------------

// File: rtl/conv_layer_stream.sv
// conv_layer_stream: streams one image channel row by row through a three-row
// line buffer. Each 3x3 window is convolved with N_KER stored kernels in
// parallel, and each result is scaled and saturated. One output set is
// produced per handshake, in raster order.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | accepting 9*N_KER kernel words
// FILL   | accepting image rows into the line buffer
// CONV   | emitting one output row, one column per handshake
// DONE   | one-cycle done pulse
module conv_layer_stream #(
  parameter int WIDTH = 9,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int N_KER = 3,
  parameter int SHIFT = 0,
  localparam int RW = ($clog2(IMG_H-2) > 0) ? $clog2(IMG_H-2) : 1,
  localparam int CW = ($clog2(IMG_W-2) > 0) ? $clog2(IMG_W-2) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   reuse_w_i,
  input  logic                   w_valid_i,
  input  logic [WIDTH-1:0]       w_data_i,
  output logic                   w_ready_o,
  input  logic                   row_valid_i,
  input  logic [IMG_W*WIDTH-1:0] row_data_i,
  output logic                   row_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [N_KER*WIDTH-1:0] out_data_o,
  output logic [RW-1:0]          out_row_o,
  output logic [CW-1:0]          out_col_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int NW   = 9*N_KER;
  localparam int WIW  = $clog2(NW);
  localparam int PW   = 2*WIDTH;
  localparam int ACCW = 2*WIDTH+4;
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {IDLE, LOAD_W, FILL, CONV, DONE} state_t;

  state_t                   state_q, state_d;
  logic signed [WIDTH-1:0]  w_q [NW];
  logic [WIW-1:0]           w_idx_q;
  logic [IMG_W*WIDTH-1:0]   lb_q [3];
  logic [1:0]               need_q;
  logic [CW-1:0]            col_q;
  logic [RW-1:0]            row_q;
  logic                     out_valid_q;
  logic [N_KER*WIDTH-1:0]   out_data_q;
  logic [CW-1:0]            ccol;
  logic [N_KER*WIDTH-1:0]   conv_res;

  logic w_fire, row_fire, out_fire, last_col, last_row, last_w, start_go, fill_last;

  assign start_go  = (state_q == IDLE) && start_i;
  assign w_fire    = (state_q == LOAD_W) && w_valid_i;
  assign row_fire  = (state_q == FILL) && row_valid_i;
  assign out_fire  = (state_q == CONV) && out_valid_q && out_ready_i;
  assign last_col  = (col_q == CW'(IMG_W-3));
  assign last_row  = (row_q == RW'(IMG_H-3));
  assign last_w    = (w_idx_q == WIW'(NW-1));
  assign fill_last = row_fire && (need_q == 2'd1);

  // Window result for kernel k at column c: signed MAC, arithmetic shift, saturation
  function automatic logic signed [WIDTH-1:0] conv_k(input int k, input int c);
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  sh;
    logic signed [PW-1:0]    prod;
    logic signed [WIDTH-1:0] px;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        px   = lb_q[i][(c+j)*WIDTH +: WIDTH];
        prod = w_q[k*9 + i*3 + j] * px;
        acc  = acc + ACCW'(prod);
      end
    end
    sh = acc >>> SHIFT;
    if (sh > SAT_MAX)      conv_k = SAT_MAX[WIDTH-1:0];
    else if (sh < SAT_MIN) conv_k = SAT_MIN[WIDTH-1:0];
    else                   conv_k = sh[WIDTH-1:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = reuse_w_i ? FILL : LOAD_W;
      LOAD_W:  if (w_fire && last_w) state_d = FILL;
      FILL:    if (fill_last) state_d = CONV;
      CONV:    if (out_fire && last_col) state_d = last_row ? DONE : FILL;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake readiness and status outputs decoded from state
  always_comb begin
    w_ready_o   = (state_q == LOAD_W);
    row_ready_o = (state_q == FILL);
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
  end

  // Kernel storage, written in arrival order; survives across images
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
      w_idx_q <= '0;
    end else begin
      if (start_go) w_idx_q <= '0;
      if (w_fire) begin
        w_q[w_idx_q] <= w_data_i;
        w_idx_q      <= w_idx_q + 1'b1;
      end
    end
  end

  // Line buffer shift (row 0 oldest) and count of rows still needed before CONV
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) lb_q[i] <= '0;
      need_q <= 2'd3;
    end else begin
      if (start_go) need_q <= 2'd3;
      if (row_fire) begin
        lb_q[0] <= lb_q[1];
        lb_q[1] <= lb_q[2];
        lb_q[2] <= row_data_i;
        need_q  <= need_q - 2'd1;
      end
      if (out_fire && last_col && !last_row) need_q <= 2'd1;
    end
  end

  // The next result is computed for the column after the current one on a handshake
  always_comb begin
    ccol     = (out_valid_q && !last_col) ? col_q + CW'(1) : col_q;
    conv_res = '0;
    for (int k = 0; k < N_KER; k++) conv_res[k*WIDTH +: WIDTH] = conv_k(k, int'(ccol));
  end

  // Registered result, position, and valid; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (start_go) begin
      col_q <= '0;
      row_q <= '0;
    end else if (fill_last) begin
      col_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (state_q == CONV) begin
      if (!out_valid_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= conv_res;
      end else if (out_ready_i) begin
        if (last_col) begin
          out_valid_q <= 1'b0;
          if (!last_row) row_q <= row_q + 1'b1;
        end else begin
          col_q      <= col_q + 1'b1;
          out_data_q <= conv_res;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_row_o   = row_q;
  assign out_col_o   = col_q;

endmodule

// File: tb/tb_conv_layer_stream.sv
// Directed bench for conv_layer_stream on a 5x5 image with two 3x3 kernels.
module tb_conv_layer_stream;
  localparam int WIDTH = 9, IMG_W = 5, IMG_H = 5, N_KER = 2, SHIFT = 0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start_i = 0, reuse_w_i = 0, w_valid_i = 0, row_valid_i = 0, out_ready_i = 0;
  logic [WIDTH-1:0] w_data_i = '0;
  logic [IMG_W*WIDTH-1:0] row_data_i = '0;
  logic w_ready_o, row_ready_o, out_valid_o, busy_o, done_o;
  logic [N_KER*WIDTH-1:0] out_data_o;
  logic [1:0] out_row_o, out_col_o;

  always #5 clk = ~clk;

  conv_layer_stream #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .N_KER(N_KER), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .reuse_w_i(reuse_w_i),
    .w_valid_i(w_valid_i), .w_data_i(w_data_i), .w_ready_o(w_ready_o),
    .row_valid_i(row_valid_i), .row_data_i(row_data_i), .row_ready_o(row_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_row_o(out_row_o), .out_col_o(out_col_o), .busy_o(busy_o), .done_o(done_o));

  typedef struct { int r; int c; int k0; int k1; } vec_t;
  vec_t tbl [45];

  int checks = 0, errors = 0;
  int got_r [16], got_c [16], got_k0 [16], got_k1 [16];
  int n_got, done_cnt, first_cyc, last_cyc;
  bit fin, abort, wr_bad;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Weight sets: 0 = k0 ones / k1 centre, 1 = all 255, 2 = all -256, 3 = k0 all -1 / k1 top-middle
  function automatic int wgt(input int set, input int idx);
    int k = idx / 9;
    int p = idx % 9;
    case (set)
      0:       return (k == 0) ? 1 : ((p == 4) ? 1 : 0);
      1:       return 255;
      2:       return -256;
      default: return (k == 0) ? -1 : ((p == 1) ? 1 : 0);
    endcase
  endfunction

  function automatic logic [IMG_W*WIDTH-1:0] mkrow(input int img, input int r);
    logic [IMG_W*WIDTH-1:0] v;
    v = '0;
    for (int c = 0; c < IMG_W; c++) v[c*WIDTH +: WIDTH] = WIDTH'((img == 0) ? r*5 + c : 255);
    return v;
  endfunction

  task automatic feed_w(input int set, input bit reuse);
    int n = 0;
    bit fire;
    if (reuse) begin
      while (!fin && !abort) begin
        @(negedge clk);
        w_valid_i = 1'b1; w_data_i = '0;
        if (w_ready_o) wr_bad = 1'b1;
      end
    end else begin
      while (n < 9*N_KER && !abort && !fin) begin
        @(negedge clk);
        w_valid_i = 1'b1; w_data_i = WIDTH'(wgt(set, n)); fire = w_ready_o;
        @(posedge clk);
        if (fire) n++;
      end
    end
    @(negedge clk);
    w_valid_i = 1'b0;
  endtask

  task automatic feed_rows(input int img);
    int n = 0;
    bit fire;
    while (n < IMG_H && !abort && !fin) begin
      @(negedge clk);
      row_valid_i = 1'b1; row_data_i = mkrow(img, n); fire = row_ready_o;
      @(posedge clk);
      if (fire) n++;
    end
    @(negedge clk);
    row_valid_i = 1'b0;
  endtask

  task automatic collect(input bit bp, input bit glitch, input bit inj);
    int cyc = 0, tail = 0;
    bit ph = 0, gdone = 0;
    logic [N_KER*WIDTH-1:0] pd;
    logic [3:0] prc;
    n_got = 0; done_cnt = 0; first_cyc = -1; last_cyc = -1;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      if (glitch && !gdone && n_got == 4) begin start_i = 1'b1; gdone = 1'b1; end
      out_ready_i = bp ? (cyc % 2 == 1) : 1'b1;
      if (done_o) done_cnt++;
      if (ph) begin
        chk("hold_valid", int'(out_valid_o), 1);
        chk("hold_data", int'(out_data_o), int'(pd));
        chk("hold_rowcol", int'({out_row_o, out_col_o}), int'(prc));
      end
      ph  = out_valid_o && !out_ready_i;
      pd  = out_data_o;
      prc = {out_row_o, out_col_o};
      if (inj && out_valid_o && out_row_o == 2'd1) begin
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid_o), 0);
        chk("rst_out_data", int'(out_data_o), 0);
        chk("rst_out_row", int'(out_row_o), 0);
        chk("rst_out_col", int'(out_col_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (done_o) done_cnt++;
        end
        chk("rst_no_done", done_cnt, 0);
        chk("rst_idle", int'(busy_o), 0);
        abort = 1'b1;
        return;
      end
      if (out_valid_o && out_ready_i && n_got < 16) begin
        got_r[n_got]  = int'(out_row_o);
        got_c[n_got]  = int'(out_col_o);
        got_k0[n_got] = int'($signed(out_data_o[WIDTH-1:0]));
        got_k1[n_got] = int'($signed(out_data_o[2*WIDTH-1:WIDTH]));
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        n_got++;
      end
      if (done_cnt > 0) tail++;
      if (tail == 4) fin = 1'b1;
      if (cyc >= 300 && !fin) begin
        chk("timeout", 0, 1);
        fin = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input int set, input int img, input bit reuse, input bit bp,
                           input bit glitch, input bit inj);
    fin = 1'b0; abort = 1'b0; wr_bad = 1'b0;
    @(negedge clk);
    if (reuse) w_valid_i = 1'b1;
    start_i = 1'b1; reuse_w_i = reuse;
    @(negedge clk);
    start_i = 1'b0; reuse_w_i = 1'b0;
    if (reuse) chk("reuse_row_ready", int'(row_ready_o), 1);
    else       chk("load_w_ready", int'(w_ready_o), 1);
    chk("busy", int'(busy_o), 1);
    fork
      feed_w(set, reuse);
      feed_rows(img);
      collect(bp, glitch, inj);
    join
  endtask

  task automatic check_frame(input int g, input bit span, input bit reuse);
    chk("out_count", n_got, 9);
    chk("done_pulses", done_cnt, 1);
    for (int i = 0; i < 9 && i < n_got; i++) begin
      chk("row", got_r[i], tbl[g*9+i].r);
      chk("col", got_c[i], tbl[g*9+i].c);
      chk("k0", got_k0[i], tbl[g*9+i].k0);
      chk("k1", got_k1[i], tbl[g*9+i].k1);
    end
    if (span) chk("throughput_span", last_cyc - first_cyc, 12);
    if (reuse) chk("w_ready_quiet", int'(wr_bad), 0);
  endtask

  initial begin
    tbl[0] = '{0, 0, 54, 6};    tbl[1] = '{0, 1, 63, 7};    tbl[2] = '{0, 2, 72, 8};
    tbl[3] = '{1, 0, 99, 11};   tbl[4] = '{1, 1, 108, 12};  tbl[5] = '{1, 2, 117, 13};
    tbl[6] = '{2, 0, 144, 16};  tbl[7] = '{2, 1, 153, 17};  tbl[8] = '{2, 2, 162, 18};
    tbl[27] = '{0, 0, -54, 1};  tbl[28] = '{0, 1, -63, 2};  tbl[29] = '{0, 2, -72, 3};
    tbl[30] = '{1, 0, -99, 6};  tbl[31] = '{1, 1, -108, 7}; tbl[32] = '{1, 2, -117, 8};
    tbl[33] = '{2, 0, -144, 11}; tbl[34] = '{2, 1, -153, 12}; tbl[35] = '{2, 2, -162, 13};
    for (int i = 0; i < 9; i++) begin
      tbl[9+i]  = '{i/3, i%3, 255, 255};
      tbl[18+i] = '{i/3, i%3, -256, -256};
      tbl[36+i] = '{i/3, i%3, 0, 0};
    end

    repeat (2) @(negedge clk);
    chk("reset_w_ready", int'(w_ready_o), 0);
    chk("reset_row_ready", int'(row_ready_o), 0);
    chk("reset_out_valid", int'(out_valid_o), 0);
    chk("reset_out_data", int'(out_data_o), 0);
    chk("reset_out_row", int'(out_row_o), 0);
    chk("reset_out_col", int'(out_col_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_done", int'(done_o), 0);
    rst_n = 1'b1;

    run_frame(0, 0, 0, 0, 0, 0); check_frame(0, 1, 0);
    run_frame(0, 0, 1, 0, 0, 0); check_frame(0, 1, 1);
    run_frame(0, 0, 1, 1, 0, 0); check_frame(0, 0, 1);
    run_frame(0, 0, 1, 0, 1, 0); check_frame(0, 1, 1);
    run_frame(1, 1, 0, 0, 0, 0); check_frame(1, 1, 0);
    run_frame(2, 1, 0, 0, 0, 0); check_frame(2, 1, 0);
    run_frame(3, 0, 0, 0, 0, 0); check_frame(3, 1, 0);
    run_frame(0, 0, 0, 0, 0, 0); check_frame(0, 1, 0);
    run_frame(0, 0, 1, 0, 0, 1);
    run_frame(0, 0, 1, 0, 0, 0); check_frame(4, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
